// File: rtl/sensor_frame_ctrl.sv
// Frame sequencer: erase -> expose -> ramp-ADC convert -> row readout, with button-set exposure.
// Define SENSOR_FRAME_CONTINUOUS_EN for back-to-back frames after the first init.
module sensor_frame_ctrl #(
  parameter int ERASE_CYCLES = 5,
  parameter int EXP_MIN      = 2,
  parameter int EXP_MAX      = 30,
  parameter int EXP_DEFAULT  = 16,
  parameter int ADC_W        = 8,
  parameter int ROWS         = 2,
  parameter int ROW_CYCLES   = 4,
  localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             exp_inc,
  input  logic             exp_dec,
  output logic             erase,
  output logic             expose,
  output logic             convert,
  output logic             read,
  output logic [ADC_W-1:0] adc_count,
  output logic [ROW_W-1:0] row_sel,
  output logic [7:0]       exp_time,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [2:0] {st_idle, st_erase, st_expose, st_convert, st_read} state_t;

`ifdef SENSOR_FRAME_CONTINUOUS_EN
  localparam state_t AFTER_READ = st_erase;
  localparam bit     CONTINUOUS = 1'b1;
`else
  localparam state_t AFTER_READ = st_idle;
  localparam bit     CONTINUOUS = 1'b0;
`endif

  localparam logic [ADC_W-1:0] ADC_MAX = '1;

  state_t           state_reg, state_next;
  logic [7:0]       phase_cnt_reg, phase_cnt_next;
  logic [ADC_W-1:0] adc_count_reg, adc_count_next;
  logic [ROW_W-1:0] row_sel_reg, row_sel_next;
  logic [7:0]       exp_time_reg, exp_time_next;
  logic [7:0]       exp_lat_reg;
  logic             frame_done_reg;

  logic erase_last, expose_last, convert_last, row_last, frame_last;
  logic btn_en;

  assign erase_last   = (phase_cnt_reg == 8'(ERASE_CYCLES - 1));
  assign expose_last  = (phase_cnt_reg == exp_lat_reg - 8'd1);
  assign convert_last = (adc_count_reg == ADC_MAX);
  assign row_last     = (phase_cnt_reg == 8'(ROW_CYCLES - 1));
  assign frame_last   = row_last && (row_sel_reg == ROW_W'(ROWS - 1));

  // A button on the same edge as an accepted init is dropped.
  assign btn_en = ((state_reg == st_idle) && !init) || (CONTINUOUS && frame_done_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= st_idle;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      st_idle:    if (init)         state_next = st_erase;
      st_erase:   if (erase_last)   state_next = st_expose;
      st_expose:  if (expose_last)  state_next = st_convert;
      st_convert: if (convert_last) state_next = st_read;
      st_read:    if (frame_last)   state_next = AFTER_READ;
      default:                      state_next = st_idle;
    endcase
  end

  always_comb begin
    erase   = 1'b0;
    expose  = 1'b0;
    convert = 1'b0;
    read    = 1'b0;
    case (state_reg)
      st_erase:   erase   = 1'b1;
      st_expose:  expose  = 1'b1;
      st_convert: convert = 1'b1;
      st_read:    read    = 1'b1;
      default:    ;
    endcase
    busy = (state_reg != st_idle);
  end

  assign adc_count  = adc_count_reg;
  assign row_sel    = row_sel_reg;
  assign exp_time   = exp_time_reg;
  assign frame_done = frame_done_reg;

  // Phase counter restarts on every state change and on every row boundary.
  always_comb begin
    phase_cnt_next = phase_cnt_reg + 8'd1;
    if ((state_next != state_reg) || (state_reg == st_idle) ||
        ((state_reg == st_read) && row_last)) begin
      phase_cnt_next = '0;
    end
  end

  always_comb begin
    adc_count_next = '0;
    if ((state_reg == st_convert) && !convert_last) begin
      adc_count_next = adc_count_reg + ADC_W'(1);
    end
  end

  always_comb begin
    row_sel_next = '0;
    if (state_reg == st_read) begin
      row_sel_next = row_sel_reg;
      if (row_last) begin
        row_sel_next = frame_last ? '0 : row_sel_reg + ROW_W'(1);
      end
    end
  end

  always_comb begin
    exp_time_next = exp_time_reg;
    if (btn_en) begin
      if (exp_inc && !exp_dec && (exp_time_reg < 8'(EXP_MAX))) begin
        exp_time_next = exp_time_reg + 8'd1;
      end else if (exp_dec && !exp_inc && (exp_time_reg > 8'(EXP_MIN))) begin
        exp_time_next = exp_time_reg - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_cnt_reg  <= '0;
      adc_count_reg  <= '0;
      row_sel_reg    <= '0;
      exp_time_reg   <= 8'(EXP_DEFAULT);
      exp_lat_reg    <= 8'(EXP_DEFAULT);
      frame_done_reg <= 1'b0;
    end else begin
      phase_cnt_reg  <= phase_cnt_next;
      adc_count_reg  <= adc_count_next;
      row_sel_reg    <= row_sel_next;
      exp_time_reg   <= exp_time_next;
      frame_done_reg <= (state_reg == st_read) && frame_last;
      // Exposure is frozen for the whole frame at the moment erase begins.
      if ((state_next == st_erase) && (state_reg != st_erase)) begin
        exp_lat_reg <= exp_time_reg;
      end
    end
  end

endmodule

// File: tb/tb_sensor_frame_ctrl.sv
// Self-checking bench for sensor_frame_ctrl: randomized buttons/inits against a
// timeline model that derives every output from the cycle offset since init.
module tb_sensor_frame_ctrl;

  localparam int ERASE_CYCLES = 5;
  localparam int EXP_MIN      = 2;
  localparam int EXP_MAX      = 30;
  localparam int EXP_DEFAULT  = 16;
  localparam int ADC_W        = 8;
  localparam int ROWS         = 2;
  localparam int ROW_CYCLES   = 4;
  localparam int ROW_W        = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef struct packed {
    logic             erase;
    logic             expose;
    logic             convert;
    logic             read;
    logic             busy;
    logic             frame_done;
    logic [ADC_W-1:0] adc;
    logic [ROW_W-1:0] row;
    logic [7:0]       exp_time;
  } obs_t;

  logic             clk = 1'b0;
  logic             reset, init, exp_inc, exp_dec;
  logic             erase, expose, convert, read, busy, frame_done;
  logic [ADC_W-1:0] adc_count;
  logic [ROW_W-1:0] row_sel;
  logic [7:0]       exp_time;
  obs_t             obs;

  int vectors     = 0;
  int miscompares = 0;
  int exp_model;

  always #5 clk = ~clk;

  sensor_frame_ctrl #(
    .ERASE_CYCLES(ERASE_CYCLES), .EXP_MIN(EXP_MIN), .EXP_MAX(EXP_MAX),
    .EXP_DEFAULT(EXP_DEFAULT), .ADC_W(ADC_W), .ROWS(ROWS), .ROW_CYCLES(ROW_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .init(init), .exp_inc(exp_inc), .exp_dec(exp_dec),
    .erase(erase), .expose(expose), .convert(convert), .read(read),
    .adc_count(adc_count), .row_sel(row_sel), .exp_time(exp_time),
    .busy(busy), .frame_done(frame_done)
  );

  assign obs = {erase, expose, convert, read, busy, frame_done, adc_count, row_sel, exp_time};

  function automatic int frame_len(input int e);
    return ERASE_CYCLES + e + (1 << ADC_W) + ROWS * ROW_CYCLES;
  endfunction

  // Expected outputs t cycles after the init edge (t<0: idle before the frame).
  function automatic obs_t model_word(input int t, input int e, input int et, input bit cont);
    obs_t w;
    int ce, cx, cc, per, p;
    w = '0;
    w.exp_time = 8'(et);
    ce  = ERASE_CYCLES;
    cx  = ce + e;
    cc  = cx + (1 << ADC_W);
    per = frame_len(e);
    if (t < 0) return w;
    if (!cont && t >= per) begin
      w.frame_done = (t == per);
      return w;
    end
    p = t % per;
    w.frame_done = (t >= per) && (p == 0);
    w.busy = 1'b1;
    if (p < ce) w.erase = 1'b1;
    else if (p < cx) w.expose = 1'b1;
    else if (p < cc) begin
      w.convert = 1'b1;
      w.adc     = ADC_W'(p - cx);
    end else begin
      w.read = 1'b1;
      w.row  = ROW_W'((p - cc) / ROW_CYCLES);
    end
    return w;
  endfunction

  // Walks the exposure setting to target using the buttons while idle.
  task automatic drive_exposure(input int target);
    for (int i = 0; i < 300 && exp_model != target; i++) begin
      exp_inc = (exp_model < target);
      exp_dec = (exp_model > target);
      @(posedge clk); #1;
      exp_model += exp_inc ? 1 : -1;
    end
    exp_inc = 1'b0;
    exp_dec = 1'b0;
  endtask

  task automatic test_reset();
    obs_t want;
    int   e;
    reset = 1'b1;
    @(posedge clk); #1;
    want = model_word(-1, 0, EXP_DEFAULT, 1'b0);
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL reset_idle got=%h want=%h", obs, want);
    end
    reset = 1'b0;
    exp_model = EXP_DEFAULT;
    drive_exposure(EXP_DEFAULT + 3);
    e = exp_model;
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    repeat (ERASE_CYCLES + e + 100) @(posedge clk);
    #1;
    want = model_word(ERASE_CYCLES + e + 100, e, e, 1'b0);
    vectors++;
    if (obs !== want || adc_count !== ADC_W'(100)) begin
      miscompares++;
      $display("FAIL reset_pre_convert got=%h want=%h", obs, want);
    end
    #2 reset = 1'b1;
    #1;
    want = model_word(-1, 0, EXP_DEFAULT, 1'b0);
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL reset_mid_convert got=%h want=%h", obs, want);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_model = EXP_DEFAULT;
  endtask

  task automatic test_exp_buttons();
    obs_t want;
    for (int i = 0; i < 125; i++) begin
      if (i < 20)      {exp_inc, exp_dec} = 2'b10;
      else if (i < 60) {exp_inc, exp_dec} = 2'b01;
      else if (i < 65) {exp_inc, exp_dec} = 2'b11;
      else             {exp_inc, exp_dec} = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      if (exp_inc && !exp_dec) exp_model = (exp_model < EXP_MAX) ? exp_model + 1 : EXP_MAX;
      else if (exp_dec && !exp_inc) exp_model = (exp_model > EXP_MIN) ? exp_model - 1 : EXP_MIN;
      want = model_word(-1, 0, exp_model, 1'b0);
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL exp_buttons i=%0d got=%h want=%h", i, obs, want);
      end
      if (i == 19 || i == 59 || i == 64) begin
        vectors++;
        if (exp_time !== ((i == 19) ? 8'(EXP_MAX) : 8'(EXP_MIN))) begin
          miscompares++;
          $display("FAIL exp_saturate i=%0d got=%0d want=%0d", i, exp_time,
                   (i == 19) ? EXP_MAX : EXP_MIN);
        end
      end
    end
    exp_inc = 1'b0;
    exp_dec = 1'b0;
  endtask

  task automatic test_default_frame();
    obs_t want;
    int   busy_cycles = 0;
    int   per;
    drive_exposure(EXP_DEFAULT);
    per = frame_len(exp_model);
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    for (int t = 0; t <= per + 3; t++) begin
      want = model_word(t, exp_model, exp_model, 1'b0);
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL default_frame t=%0d got=%h want=%h", t, obs, want);
      end
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
    end
    vectors++;
    if (busy_cycles != 285) begin
      miscompares++;
      $display("FAIL default_frame_busy got=%0d want=285", busy_cycles);
    end
  endtask

  task automatic test_busy_ignore();
    obs_t want;
    int   e, per;
    drive_exposure(int'($urandom_range(EXP_MIN, EXP_MAX)));
    e   = exp_model;
    per = frame_len(e);
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    for (int t = 0; t <= per + 3; t++) begin
      want = model_word(t, e, e, 1'b0);
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL busy_ignore t=%0d got=%h want=%h", t, obs, want);
      end
      if (t < per) begin
        {init, exp_inc, exp_dec} = 3'($urandom_range(0, 7));
        if (t == ERASE_CYCLES + 1) {init, exp_inc} = 2'b11;
      end else begin
        {init, exp_inc, exp_dec} = 3'b000;
      end
      @(posedge clk); #1;
    end
    {init, exp_inc, exp_dec} = 3'b000;
  endtask

  task automatic test_init_with_inc();
    obs_t want;
    int   per;
    drive_exposure(EXP_DEFAULT);
    per = frame_len(exp_model);
    init    = 1'b1;
    exp_inc = 1'b1;
    @(posedge clk); #1;
    init    = 1'b0;
    exp_inc = 1'b0;
    for (int t = 0; t <= per + 2; t++) begin
      want = model_word(t, exp_model, exp_model, 1'b0);
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL init_with_inc t=%0d got=%h want=%h", t, obs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    obs_t want;
    int   e, per;
    drive_exposure(int'($urandom_range(EXP_MIN, EXP_MAX)));
    e   = exp_model;
    per = frame_len(e);
    init = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t <= per; t++) begin
      want = model_word(t, e, e, 1'b0);
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL back_to_back_f1 t=%0d got=%h want=%h", t, obs, want);
      end
      @(posedge clk); #1;
    end
    init = 1'b0;
    for (int t = 0; t <= per + 1; t++) begin
      want = model_word(t, e, e, 1'b0);
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL back_to_back_f2 t=%0d got=%h want=%h", t, obs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_continuous();
    obs_t want;
    int   per;
    drive_exposure(EXP_DEFAULT);
    per = frame_len(exp_model);
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    for (int t = 0; t <= 3 * per + 2; t++) begin
      want = model_word(t, exp_model, exp_model, 1'b1);
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL continuous t=%0d got=%h want=%h", t, obs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    init      = 1'b0;
    exp_inc   = 1'b0;
    exp_dec   = 1'b0;
    exp_model = EXP_DEFAULT;
    test_reset();
    test_exp_buttons();
`ifdef SENSOR_FRAME_CONTINUOUS_EN
    test_continuous();
`else
    test_default_frame();
    test_busy_ignore();
    test_init_with_inc();
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
